op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  queue can accept; equals not-full.
REQ-006 SHALL have port cmd_modo  input  2  operation: 00 NOP, 01 ADD, 10 SUB, 11 CLR.
REQ-007 SHALL have port cmd_a, cmd_b  input  4 each  operands.
REQ-008 SHALL have port enb  output  1  issue strobe to the arithmetic stage.
REQ-009 SHALL have port modo  output  2  operation to the arithmetic stage.
REQ-010 SHALL have port A, B  output  4 each  operands to the arithmetic stage.
REQ-011 SHALL have port Q  input  4  registered result from the arithmetic stage.
REQ-012 SHALL have port RCO  input  1  registered carry/borrow from the arithmetic stage.
REQ-013 SHALL have port res_valid  output  1  result held.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port res_q, res_rco, res_modo  output  4/1/2  captured result and its operation.

Function
REQ-016 SHALL push {modo,a,b} when cmd_valid and cmd_ready are both high at a clock edge.
REQ-017 SHALL be an FSM with states IDLE, ISSUE, CAPTURE, HOLD.
REQ-018 IDLE with queue non-empty SHALL pop the head; a popped NOP is discarded, state stays IDLE, and no result is produced; otherwise the next state is ISSUE.
REQ-019 ISSUE SHALL drive enb=1 with the popped modo/A/B for exactly one cycle, then go to CAPTURE.
REQ-020 CAPTURE SHALL hold enb=0 and latch Q, RCO and modo into res_q/res_rco/res_modo at the closing edge, then go to HOLD.
REQ-021 HOLD SHALL assert res_valid; res_* SHALL stay stable until res_valid and res_ready are both high.
REQ-022 On the HOLD handshake: queue non-empty pops the head (NOP discarded, then IDLE) and goes to ISSUE; queue empty goes to IDLE.
REQ-023 enb, modo, A and B SHALL be registered outputs; outside ISSUE enb=0 and modo/A/B hold their last values.
REQ-024 Latency from an empty queue in IDLE: with the command handshake in cycle 0, enb is high in cycle 2 and res_valid is high in cycle 4.
REQ-025 Simultaneous push and pop SHALL both take effect, leaving the count unchanged.
REQ-026 A push while full SHALL be impossible because cmd_ready=0; a pop while empty SHALL never occur.
REQ-027 Queue pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 No arithmetic SHALL be performed locally; Q/RCO are passed through unmodified.

Reset
REQ-029 rst high SHALL immediately force state IDLE, queue empty, enb=0, modo=00, A=B=0, res_valid=0, res_q=0, res_rco=0, res_modo=00.
REQ-030 Reset mid-operation (ISSUE/CAPTURE/HOLD) SHALL abandon the operation with no result emitted and all queued commands dropped.
REQ-031 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 Package op_seq_pkg SHALL hold the modo constants (MODO_NOP/ADD/SUB/CLR), the state enum, and the default FIFO depth.
REQ-033 The command queue SHALL be a sub-module op_fifo (sync push/pop, full/empty, async active-high reset).

Verification (behavioural 4-bit stage model: Q = sum/diff mod 16, RCO = carry-out/borrow-out)
REQ-034 ADD a=7, b=5 -> enb pulse in cycle 2; res_valid in cycle 4 with res_q=12, res_rco=0, res_modo=01.
REQ-035 ADD 9+8, SUB 3-5, CLR 6,6 back-to-back with res_ready=1 -> results (1,1), (14,1), (0,0) in order.
REQ-036 NOP then ADD 1+1 -> exactly one result (2,0); enb never high for the NOP.
REQ-037 res_ready=0, push 6 commands -> first reaches HOLD, 4 queue, cmd_ready=0 after the 5th; res_ready=1 drains all 5 in order; the 6th is offered again after cmd_ready rises.
REQ-038 rst pulse during CAPTURE with 2 queued -> enb=0, res_valid=0, cmd_ready=1; no result ever appears.
REQ-039 res_ready toggling 1/0 each cycle during HOLD -> res_q stable until handshake; no result lost or duplicated.

Source files
------------

// File: rtl/op_seq_pkg.sv
// Shared constants and types for the operation sequencer: opcode values,
// sequencer states, the queued command layout and the default queue depth.
package op_seq_pkg;

    localparam logic [1:0] MODO_NOP = 2'b00;
    localparam logic [1:0] MODO_ADD = 2'b01;
    localparam logic [1:0] MODO_SUB = 2'b10;
    localparam logic [1:0] MODO_CLR = 2'b11;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        HOLD    = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0] modo;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

endpackage

// File: rtl/op_fifo.sv
// Command queue: synchronous push/pop, head visible combinationally.
// Push is ignored while full and pop while empty; pointers wrap modulo DEPTH.
module op_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Queues commands and issues them one at a time to an external registered
// arithmetic stage, holding each result until the consumer takes it.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_modo,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic       enb,
    output logic [1:0] modo,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] Q,
    input  logic       RCO,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_q,
    output logic       res_rco,
    output logic [1:0] res_modo
);

    state_t     r_state;
    state_t     w_state_nxt;
    cmd_t       w_cmd_in;
    cmd_t       w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic       r_enb;
    logic [1:0] r_modo;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_res_q;
    logic       r_res_rco;
    logic [1:0] r_res_modo;

    assign w_cmd_in.modo = cmd_modo;
    assign w_cmd_in.a    = cmd_a;
    assign w_cmd_in.b    = cmd_b;
    assign cmd_ready     = !w_full;
    assign w_push        = cmd_valid && cmd_ready;

    op_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_cmd_in),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A popped NOP is consumed without issuing, so w_issue only rises for real ops.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.modo != MODO_NOP) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE:   w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = HOLD;
            HOLD: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head.modo != MODO_NOP) begin
                            w_issue     = 1'b1;
                            w_state_nxt = ISSUE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enb      <= 1'b0;
            r_modo     <= MODO_NOP;
            r_a        <= '0;
            r_b        <= '0;
            r_res_q    <= '0;
            r_res_rco  <= 1'b0;
            r_res_modo <= MODO_NOP;
        end else begin
            r_enb <= w_issue;
            if (w_issue) begin
                r_modo <= w_head.modo;
                r_a    <= w_head.a;
                r_b    <= w_head.b;
            end
            // The stage registered its result on the ISSUE edge, so it is valid now.
            if (r_state == CAPTURE) begin
                r_res_q    <= Q;
                r_res_rco  <= RCO;
                r_res_modo <= r_modo;
            end
        end
    end

    assign enb       = r_enb;
    assign modo      = r_modo;
    assign A         = r_a;
    assign B         = r_b;
    assign res_valid = (r_state == HOLD);
    assign res_q     = r_res_q;
    assign res_rco   = r_res_rco;
    assign res_modo  = r_res_modo;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: registered 4-bit arithmetic stage model, directed
// scenarios and a randomized phase scored against an in-order result queue.
module tb_op_sequencer;
    import op_seq_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_modo = 2'b00;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic       enb;
    logic [1:0] modo;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic       RCO;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_q;
    logic       res_rco;
    logic [1:0] res_modo;

    int         checks = 0;
    int         errors = 0;
    int         n_results = 0;
    int         enb_cnt = 0;
    logic       last_push = 1'b0;
    logic       last_enb = 1'b0;
    logic       prev_hold = 1'b0;
    logic [6:0] held = '0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    op_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_modo  (cmd_modo),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .enb       (enb),
        .modo      (modo),
        .A         (A),
        .B         (B),
        .Q         (Q),
        .RCO       (RCO),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_q     (res_q),
        .res_rco   (res_rco),
        .res_modo  (res_modo)
    );

    // External arithmetic stage: registers its result on the edge where enb is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            Q   <= 4'd0;
            RCO <= 1'b0;
        end else if (enb) begin
            case (modo)
                MODO_ADD: {RCO, Q} <= {1'b0, A} + {1'b0, B};
                MODO_SUB: {RCO, Q} <= {1'b0, A} - {1'b0, B};
                default:  {RCO, Q} <= 5'd0;
            endcase
        end
    end

    // Expected {q, rco, modo} computed from plain integer arithmetic.
    function automatic logic [6:0] ref_result(logic [1:0] m, logic [3:0] a, logic [3:0] b);
        int s;
        bit c;
        s = 0;
        c = 1'b0;
        if (m == MODO_ADD) s = int'(a) + int'(b);
        else if (m == MODO_SUB) s = int'(a) - int'(b);
        if (s > 15) begin
            c = 1'b1;
            s = s - 16;
        end else if (s < 0) begin
            c = 1'b1;
            s = s + 16;
        end
        return {4'(s), c, m};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        last_push = cmd_valid && cmd_ready;
        last_enb  = enb;
        if (enb) begin
            enb_cnt++;
            check("enb_not_nop", 32'(modo != MODO_NOP), 32'd1);
        end
        if (prev_hold) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_stable", 32'({res_q, res_rco, res_modo}), 32'(held));
        end
        if (res_valid && res_ready) begin
            n_results++;
            if (exp_q.size() == 0) check("result_pending", 32'(exp_q.size()), 32'd1);
            else check("result", 32'({res_q, res_rco, res_modo}), 32'(exp_q.pop_front()));
        end
        prev_hold = res_valid && !res_ready;
        held      = {res_q, res_rco, res_modo};
        if (last_push && cmd_modo != MODO_NOP) exp_q.push_back(ref_result(cmd_modo, cmd_a, cmd_b));
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [1:0] m, logic [3:0] a, logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_modo  = m;
        cmd_a     = a;
        cmd_b     = b;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (last_push) break;
        end
        check("send_accepted", 32'(last_push), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(bit toggle);
        res_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !res_valid) break;
            if (toggle) res_ready = ~res_ready;
            cyc();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(res_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        check("rst_enb", 32'(enb), 32'd0);
        check("rst_modo", 32'(modo), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_B", 32'(B), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res", 32'({res_q, res_rco, res_modo}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        prev_hold = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int base;
        int k;

        do_reset();
        cyc();

        // Single ADD: handshake in cycle 0, enb in cycle 2, result held in cycle 4.
        send(MODO_ADD, 4'd7, 4'd5);
        check("lat_c1_enb", 32'(enb), 32'd0);
        cyc();
        check("lat_c2_enb", 32'(enb), 32'd1);
        check("lat_c2_op", 32'({modo, A, B}), 32'({MODO_ADD, 4'd7, 4'd5}));
        cyc();
        check("lat_c3_enb", 32'(enb), 32'd0);
        check("lat_c3_valid", 32'(res_valid), 32'd0);
        cyc();
        check("lat_c4_valid", 32'(res_valid), 32'd1);
        check("lat_c4_res", 32'({res_q, res_rco, res_modo}), 32'({4'd12, 1'b0, MODO_ADD}));
        drain(1'b0);

        // Back-to-back ADD/SUB/CLR with the consumer always ready.
        base = n_results;
        res_ready = 1'b1;
        send(MODO_ADD, 4'd9, 4'd8);
        send(MODO_SUB, 4'd3, 4'd5);
        send(MODO_CLR, 4'd6, 4'd6);
        drain(1'b0);
        check("b2b_count", 32'(n_results - base), 32'd3);

        // A NOP produces neither an issue strobe nor a result.
        base    = n_results;
        enb_cnt = 0;
        send(MODO_NOP, 4'd4, 4'd4);
        send(MODO_ADD, 4'd1, 4'd1);
        drain(1'b0);
        check("nop_enb_count", 32'(enb_cnt), 32'd1);
        check("nop_result_count", 32'(n_results - base), 32'd1);

        // Consumer stalled: one command in HOLD plus a full queue blocks the sixth.
        base = n_results;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(MODO_ADD, 4'(i + 2), 4'(3 * i));
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_holding", 32'(res_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_modo  = MODO_SUB;
        cmd_a     = 4'd2;
        cmd_b     = 4'd9;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("full_no_push", 32'(last_push), 32'd0);
        end
        res_ready = 1'b1;
        send(MODO_SUB, 4'd2, 4'd9);
        drain(1'b0);
        check("full_result_count", 32'(n_results - base), 32'd6);

        // Reset while a result is being captured, with two commands still queued.
        res_ready = 1'b1;
        send(MODO_ADD, 4'd15, 4'd15);
        send(MODO_SUB, 4'd8, 4'd1);
        send(MODO_ADD, 4'd2, 4'd2);
        k = 0;
        while (!last_enb && k < 10) begin
            cyc();
            k++;
        end
        check("capture_reached", 32'(last_enb), 32'd1);
        check("capture_enb", 32'(enb), 32'd0);
        do_reset();
        check("post_rst_valid", 32'(res_valid), 32'd0);
        base      = n_results;
        enb_cnt   = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check("post_rst_results", 32'(n_results - base), 32'd0);
        check("post_rst_enb", 32'(enb_cnt), 32'd0);

        // Consumer ready toggling every cycle while results are held.
        base = n_results;
        res_ready = 1'b0;
        send(MODO_SUB, 4'd0, 4'd1);
        send(MODO_ADD, 4'd8, 4'd8);
        send(MODO_CLR, 4'd3, 4'd0);
        drain(1'b1);
        check("toggle_result_count", 32'(n_results - base), 32'd3);

        // Randomized traffic and back-pressure.
        for (int i = 0; i < 600; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_modo  = 2'($urandom);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        cmd_valid = 1'b0;
        drain(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
